// File: rtl/cnt16_pwm.sv
// cnt16_pwm: turns the upstream 4-bit free-running count into a registered
// PWM waveform. A new duty value is taken through a valid/ready handshake,
// held in a one-entry staging register, and only applied at a counter wrap
// (MAX->0) so the waveform never glitches mid-period. The block also emits a
// one-cycle wrap pulse and a running count of wraps.
module cnt16_pwm #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned PER_W = 8,
   parameter bit          POL   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W:0]   duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             wrap_pulse,
   output logic [PER_W-1:0] period_cnt
);

   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cntPrev_q;
   logic [CNT_W:0]   dutyAct_q,  dutyAct_d;
   logic             pendV_q,    pendV_d;
   logic [CNT_W:0]   pend_q,     pend_d;
   logic             pwm_q,      pwm_d;
   logic             wrapPulse_q;
   logic [PER_W-1:0] periodCnt_q, periodCnt_d;

   logic             wrapNow;
   logic             accept;
   logic [CNT_W:0]   dutyEff;

   // Wrap detection, handshake acceptance and the duty value that governs
   // this cycle; a staged duty is used on the wrap cycle itself so the new
   // period starts with the new duty from count 0.
   always_comb begin
      wrapNow = (cntPrev_q == MAX) && (cnt == '0);
      accept  = duty_valid && !pendV_q;
      dutyEff = (wrapNow && pendV_q) ? pend_q : dutyAct_q;
   end

   // Next-state for the staging register, active duty, PWM level and the
   // wrap counter. Acceptance only happens with the stage empty, so it can
   // never collide with a wrap that consumes a staged value.
   always_comb begin
      dutyAct_d   = dutyAct_q;
      pendV_d     = pendV_q;
      pend_d      = pend_q;
      periodCnt_d = periodCnt_q;
      pwm_d       = (({1'b0, cnt}) < dutyEff) ? POL : ~POL;
      if (wrapNow && pendV_q) begin
         dutyAct_d = pend_q;
         pendV_d   = 1'b0;
      end
      if (accept) begin
         pend_d  = duty_in;
         pendV_d = 1'b1;
      end
      if (wrapNow) begin
         periodCnt_d = periodCnt_q + PER_W'(1);
      end
   end

   // State registers; reset clears any staged duty and parks the output
   // at its inactive level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntPrev_q   <= '0;
         dutyAct_q   <= '0;
         pendV_q     <= 1'b0;
         pend_q      <= '0;
         pwm_q       <= ~POL;
         wrapPulse_q <= 1'b0;
         periodCnt_q <= '0;
      end else begin
         cntPrev_q   <= cnt;
         dutyAct_q   <= dutyAct_d;
         pendV_q     <= pendV_d;
         pend_q      <= pend_d;
         pwm_q       <= pwm_d;
         wrapPulse_q <= wrapNow;
         periodCnt_q <= periodCnt_d;
      end
   end

   assign duty_ready = ~pendV_q;
   assign pwm_out    = pwm_q;
   assign wrap_pulse = wrapPulse_q;
   assign period_cnt = periodCnt_q;

endmodule

// File: tb/tb_cnt16_pwm.sv
// tb_cnt16_pwm: directed plus randomized bench for cnt16_pwm. A behavioural
// model (active duty, a staging queue, a wrap tally) predicts every output
// each cycle from the stimulus alone.
module tb_cnt16_pwm;

   logic       clk;
   logic       rst_n;
   logic [3:0] cnt;
   logic [4:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [7:0] period_cnt;

   int nVec = 0;
   int nMis = 0;

   int mActive;
   int mStaged[$];
   int mPrevCnt;
   int mWraps;
   int cntDrv;
   int highCount;
   int wrapCount;
   int startPeriod;
   int holdDuty;

   cnt16_pwm #(.CNT_W(4), .PER_W(8), .POL(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .duty_in    (duty_in),
      .duty_valid (duty_valid),
      .duty_ready (duty_ready),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .period_cnt (period_cnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mActive  = 0;
      mStaged.delete();
      mPrevCnt = 0;
      mWraps   = 0;
   endtask

   // One clock cycle: drive inputs, predict, clock, compare.
   task automatic applyStimulus(input int c, input bit v, input int d);
      bit wrap;
      bit accepted;
      int eff;
      bit expPwm;
      cnt        = c[3:0];
      duty_valid = v;
      duty_in    = d[4:0];
      #1;
      checkOutput("duty_ready", 32'(duty_ready), 32'(mStaged.size() == 0));
      wrap     = (mPrevCnt == 15) && (c == 0);
      accepted = v && (mStaged.size() == 0);
      eff      = (wrap && mStaged.size() != 0) ? mStaged[0] : mActive;
      expPwm   = (c < eff);
      if (wrap && mStaged.size() != 0) begin
         mActive = mStaged.pop_front();
      end
      if (accepted) mStaged.push_back(d);
      if (wrap) mWraps++;
      mPrevCnt = c;
      @(posedge clk);
      #1;
      checkOutput("pwm_out", 32'(pwm_out), 32'(expPwm));
      checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(wrap));
      checkOutput("period_cnt", 32'(period_cnt), 32'(mWraps % 256));
      if (pwm_out === 1'b1) highCount++;
      if (wrap_pulse === 1'b1) wrapCount++;
   endtask

   // One cnt16-style cycle: counter advances by one each call.
   task automatic tick(input bit v, input int d);
      applyStimulus(cntDrv, v, d);
      cntDrv = (cntDrv + 1) % 16;
   endtask

   task automatic runToCnt(input int target);
      while (cntDrv != target) tick(1'b0, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      cnt        = '0;
      duty_in    = '0;
      duty_valid = 1'b0;
      cntDrv     = 0;
      highCount  = 0;
      wrapCount  = 0;
      modelReset();

      // Reset with the counter running: outputs stay at reset values.
      for (int i = 0; i < 2; i++) begin
         cnt = cntDrv[3:0];
         @(posedge clk);
         #1;
         checkOutput("rst_pwm", 32'(pwm_out), 32'(0));
         checkOutput("rst_wrap", 32'(wrap_pulse), 32'(0));
         checkOutput("rst_period", 32'(period_cnt), 32'(0));
         checkOutput("rst_ready", 32'(duty_ready), 32'(1));
         cntDrv++;
      end
      rst_n = 1'b1;
      modelReset();

      // Load duty 4 before the first wrap, then three full periods.
      tick(1'b1, 4);
      runToCnt(0);
      checkOutput("pre_wrap_high", 32'(highCount), 32'(0));
      tick(1'b0, 0);
      runToCnt(0);
      highCount = 0;
      wrapCount = 0;
      for (int i = 0; i < 48; i++) tick(1'b0, 0);
      checkOutput("duty4_high", 32'(highCount), 32'(12));
      checkOutput("duty4_wraps", 32'(wrapCount), 32'(3));

      // Duty 0 then duty 16 over three periods each.
      tick(1'b1, 0);
      runToCnt(0);
      tick(1'b0, 0);
      runToCnt(0);
      highCount = 0;
      for (int i = 0; i < 48; i++) tick(1'b0, 0);
      checkOutput("duty0_high", 32'(highCount), 32'(0));
      tick(1'b1, 16);
      runToCnt(0);
      tick(1'b0, 0);
      runToCnt(0);
      highCount = 0;
      for (int i = 0; i < 48; i++) tick(1'b0, 0);
      checkOutput("duty16_high", 32'(highCount), 32'(48));

      // Staging and backpressure: duty 8 staged, duty 2 held valid behind it.
      runToCnt(3);
      tick(1'b1, 8);
      for (int i = 0; i < 20; i++) tick(1'b1, 2);
      for (int i = 0; i < 32; i++) tick(1'b0, 0);

      // Accept exactly on the wrap cycle.
      runToCnt(0);
      tick(1'b1, 12);
      for (int i = 0; i < 40; i++) tick(1'b0, 0);

      // Upstream counter restart 9->0 with duty 6 pending: not a wrap.
      runToCnt(1);
      tick(1'b1, 6);
      runToCnt(10);
      startPeriod = mWraps;
      cntDrv = 0;
      for (int i = 0; i < 15; i++) tick(1'b0, 0);
      checkOutput("restart_period", 32'(period_cnt), 32'(startPeriod % 256));
      checkOutput("restart_ready", 32'(duty_ready), 32'(0));
      for (int i = 0; i < 20; i++) tick(1'b0, 0);

      // Randomized traffic with occasional upstream restarts.
      holdDuty = -1;
      for (int i = 0; i < 800; i++) begin
         bit v;
         if ($urandom_range(0, 60) == 0) cntDrv = 0;
         if (holdDuty < 0 && $urandom_range(0, 3) == 0) holdDuty = $urandom_range(0, 17);
         if (holdDuty > 16) holdDuty = 16;
         v = (holdDuty >= 0);
         if (v && mStaged.size() == 0) begin
            tick(1'b1, holdDuty);
            holdDuty = -1;
         end else begin
            tick(v, (holdDuty >= 0) ? holdDuty : int'($urandom_range(0, 31)));
         end
      end

      // 256 periods: period counter comes back to its starting value.
      runToCnt(0);
      startPeriod = int'(period_cnt);
      wrapCount = 0;
      for (int i = 0; i < 256 * 16; i++) tick(1'b0, 0);
      checkOutput("roll_wraps", 32'(wrapCount), 32'(256));
      checkOutput("roll_period", 32'(period_cnt), 32'(startPeriod));

      // Asynchronous reset mid-period drops a staged duty.
      runToCnt(5);
      tick(1'b1, 9);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_ready", 32'(duty_ready), 32'(1));
      checkOutput("async_period", 32'(period_cnt), 32'(0));
      checkOutput("async_pwm", 32'(pwm_out), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      for (int i = 0; i < 40; i++) tick(1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
